// File: rtl/flash_pkg.sv
// Shared definitions for the flash read responder: bus widths, the read FSM
// state type and the fixed Avalon burst count.
package flash_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Single-word reads only.
    localparam logic [5:0] FLASH_BURST = 6'd1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        DONE,
        RELEASE
    } flash_rd_state_t;

endpackage

// File: rtl/flash_read_ctrl_if.sv
// Bundles the sequencer handshake (start/address/byteenable -> done/error/data/busy)
// and the Avalon-MM flash data port into one interface.
//   slave  : the read controller (consumes requests, drives the Avalon master side)
//   master : the environment (sequencer + flash IP)
interface flash_read_ctrl_if;
    import flash_pkg::*;

    // Sequencer side
    logic              start;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              done;
    logic              error;
    logic [DATA_W-1:0] data;
    logic              busy;

    // Avalon-MM flash side
    logic              flash_mem_read;
    logic [ADDR_W-1:0] flash_mem_address;
    logic [BE_W-1:0]   flash_mem_byteenable;
    logic [5:0]        flash_mem_burstcount;
    logic              flash_mem_waitrequest;
    logic              flash_mem_readdatavalid;
    logic [DATA_W-1:0] flash_mem_readdata;

    modport slave (
        input  start, address, byteenable,
        input  flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata,
        output done, error, data, busy,
        output flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount
    );

    modport master (
        output start, address, byteenable,
        output flash_mem_waitrequest, flash_mem_readdatavalid, flash_mem_readdata,
        input  done, error, data, busy,
        input  flash_mem_read, flash_mem_address, flash_mem_byteenable, flash_mem_burstcount
    );

endinterface

// File: rtl/flash_read_ctrl.sv
// Flash-side responder for the song player's startFlash/endFlash handshake.
// Accepts one read request, performs a single-word Avalon-MM read (honouring
// waitrequest and variable readdatavalid latency), and returns the word with a
// one-cycle done pulse. A timeout abandons the read and reports error=1, data=0.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : flash_read_ctrl_if.slave (sequencer handshake + Avalon master)
module flash_read_ctrl
    import flash_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    flash_read_ctrl_if.slave  bus
);

    localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

    flash_rd_state_t   r_state;
    logic [9:0]        r_cnt;
    logic              r_done;
    logic              r_error;
    logic              r_busy;
    logic              r_read;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_addr;
    logic [BE_W-1:0]   r_be;

    logic w_timeout;
    assign w_timeout = (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= 10'd0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_busy  <= 1'b0;
            r_read  <= 1'b0;
            r_data  <= '0;
            r_addr  <= '0;
            r_be    <= 4'h0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_cnt <= 10'd0;
                    if (bus.start) begin
                        r_addr  <= bus.address;
                        r_be    <= bus.byteenable;
                        r_error <= 1'b0;
                        r_busy  <= 1'b1;
                        r_read  <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + 10'd1;
                    // Real data wins over a coincident timeout.
                    if (!bus.flash_mem_waitrequest && bus.flash_mem_readdatavalid) begin
                        r_read  <= 1'b0;
                        r_data  <= bus.flash_mem_readdata;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        // Only case where read drops while waitrequest may be high.
                        r_read  <= 1'b0;
                        r_data  <= '0;
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (!bus.flash_mem_waitrequest) begin
                        r_read  <= 1'b0;
                        r_state <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    r_cnt <= r_cnt + 10'd1;
                    if (bus.flash_mem_readdatavalid) begin
                        r_data  <= bus.flash_mem_readdata;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_timeout) begin
                        r_data  <= '0;
                        r_error <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_cnt   <= 10'd0;
                    r_state <= RELEASE;
                end
                RELEASE: begin
                    // Hold off until the sequencer drops start so it cannot retrigger.
                    if (!bus.start) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.done                 = r_done;
    assign bus.error                = r_error;
    assign bus.data                 = r_data;
    assign bus.busy                 = r_busy;
    assign bus.flash_mem_read       = r_read;
    assign bus.flash_mem_address    = r_addr;
    assign bus.flash_mem_byteenable = r_be;
    assign bus.flash_mem_burstcount = FLASH_BURST;

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Self-checking bench for flash_read_ctrl. Directed sequencer stimulus pushes
// the expected {error,data} of each read into a scoreboard queue; a monitor pops
// and compares whenever done pulses. A small Avalon responder model supplies
// configurable wait states and readdatavalid latency.
module tb_flash_read_ctrl;

    logic clk;
    logic reset_n;

    flash_read_ctrl_if bus ();

    flash_read_ctrl #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   accepts = 0;

    // Responder configuration (written by the main sequence only).
    int          cfg_ws = 0;
    int          cfg_lat = 0;
    bit          cfg_never = 0;
    logic [31:0] cfg_word = '0;
    bit          stray_req = 0;
    logic [31:0] stray_word = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("done_seen", {31'd0, bus.done}, 32'd1);
    endtask

    // Avalon responder: decides waitrequest/readdatavalid on the falling edge
    // for the next rising edge.
    initial begin : responder
        bit in_cmd   = 0;
        bit pending  = 0;
        bit stray_ack = 0;
        int ws_left  = 0;
        int lat_left = 0;
        bus.flash_mem_waitrequest   = 1'b1;
        bus.flash_mem_readdatavalid = 1'b0;
        bus.flash_mem_readdata      = '0;
        forever begin
            @(negedge clk);
            bus.flash_mem_readdatavalid = 1'b0;
            if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                bus.flash_mem_readdatavalid = 1'b1;
                bus.flash_mem_readdata      = stray_word;
            end else if (pending) begin
                if (lat_left == 0) begin
                    pending = 0;
                    bus.flash_mem_readdatavalid = 1'b1;
                    bus.flash_mem_readdata      = cfg_word;
                end else begin
                    lat_left--;
                end
            end else if (bus.flash_mem_read === 1'b1) begin
                if (!in_cmd) begin
                    in_cmd  = 1;
                    ws_left = cfg_ws;
                    accepts++;
                end
                if (ws_left > 0) begin
                    bus.flash_mem_waitrequest = 1'b1;
                    ws_left--;
                end else begin
                    bus.flash_mem_waitrequest = 1'b0;
                    in_cmd = 0;
                    if (!cfg_never) begin
                        if (cfg_lat == 0) begin
                            bus.flash_mem_readdatavalid = 1'b1;
                            bus.flash_mem_readdata      = cfg_word;
                        end else begin
                            pending  = 1;
                            lat_left = cfg_lat - 1;
                        end
                    end
                end
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected none (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_error", {31'd0, bus.error}, {31'd0, e.err});
                    chk("done_data", bus.data, e.data);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int a0;
        int bad;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.address    = '0;
        bus.byteenable = '0;
        repeat (2) tick();

        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_error", {31'd0, bus.error}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_read", {31'd0, bus.flash_mem_read}, 32'd0);
        chk("rst_data", bus.data, 32'd0);
        chk("rst_addr", {9'd0, bus.flash_mem_address}, 32'd0);
        chk("rst_be", {28'd0, bus.flash_mem_byteenable}, 32'd0);
        chk("burstcount", {26'd0, bus.flash_mem_burstcount}, 32'd1);
        reset_n = 1'b1;
        tick();

        // Zero-wait read, data on the accept edge.
        cfg_ws = 0; cfg_lat = 0; cfg_never = 0; cfg_word = 32'hDEADBEEF;
        exp_q.push_back('{1'b0, 32'hDEADBEEF});
        a0 = accepts;
        bus.start = 1'b1; bus.address = 23'h00010; bus.byteenable = 4'hF;
        tick();  // edge N
        chk("zw_read_hi", {31'd0, bus.flash_mem_read}, 32'd1);
        chk("zw_busy", {31'd0, bus.busy}, 32'd1);
        chk("zw_addr", {9'd0, bus.flash_mem_address}, 32'h10);
        chk("zw_be", {28'd0, bus.flash_mem_byteenable}, 32'hF);
        tick();  // accept + data edge
        chk("zw_read_lo", {31'd0, bus.flash_mem_read}, 32'd0);
        chk("zw_done", {31'd0, bus.done}, 32'd1);
        tick();
        chk("zw_done_lo", {31'd0, bus.done}, 32'd0);
        chk("zw_busy_held", {31'd0, bus.busy}, 32'd1);
        bus.start = 1'b0;
        tick();
        chk("zw_busy_lo", {31'd0, bus.busy}, 32'd0);
        chk("zw_reads", accepts - a0, 32'd1);

        // Three wait states, data five cycles after accept; top address boundary.
        cfg_ws = 3; cfg_lat = 5; cfg_word = 32'hA5A50F0F;
        exp_q.push_back('{1'b0, 32'hA5A50F0F});
        bus.start = 1'b1; bus.address = 23'h7FFFFF; bus.byteenable = 4'h3;
        tick();  // edge N
        bus.address = 23'h0; bus.byteenable = 4'hF;  // must not affect the read
        n = 0;
        while (bus.flash_mem_read === 1'b1 && n < 10) begin
            n++;
            chk("ws_addr_const", {9'd0, bus.flash_mem_address}, 32'h7FFFFF);
            chk("ws_be_const", {28'd0, bus.flash_mem_byteenable}, 32'h3);
            tick();
        end
        chk("ws_read_cycles", n, 32'd4);
        wait_done(n);
        chk("ws_data_latency", n, 32'd5);
        tick();
        chk("ws_single_pulse", {31'd0, bus.done}, 32'd0);
        bus.start = 1'b0;
        tick();

        // Start held well past done: one read only, then a fresh request.
        cfg_ws = 0; cfg_lat = 2; cfg_word = 32'h13579BDF;
        exp_q.push_back('{1'b0, 32'h13579BDF});
        a0 = accepts;
        bus.start = 1'b1; bus.address = 23'h00123; bus.byteenable = 4'hF;
        wait_done(n);
        bad = 0;
        repeat (20) begin
            tick();
            if (bus.busy !== 1'b1 || bus.flash_mem_read !== 1'b0) bad++;
        end
        chk("held_busy_noread", bad, 32'd0);
        chk("held_one_read", accepts - a0, 32'd1);
        bus.start = 1'b0;
        tick();
        chk("held_busy_lo", {31'd0, bus.busy}, 32'd0);
        tick();
        cfg_word = 32'h2468ACE0;
        exp_q.push_back('{1'b0, 32'h2468ACE0});
        bus.start = 1'b1;
        wait_done(n);
        chk("held_second_read", accepts - a0, 32'd2);
        bus.start = 1'b0;
        tick();
        tick();

        // Timeout: command accepted but data never returns.
        cfg_never = 1;
        exp_q.push_back('{1'b1, 32'h0});
        bus.start = 1'b1; bus.address = 23'h00055;
        tick();  // edge N
        repeat (15) tick();
        chk("to_not_yet", {31'd0, bus.done}, 32'd0);
        tick();  // edge N+16
        chk("to_done", {31'd0, bus.done}, 32'd1);
        chk("to_error", {31'd0, bus.error}, 32'd1);
        chk("to_data", bus.data, 32'd0);
        tick();
        bus.start = 1'b0;
        tick();
        chk("to_busy_lo", {31'd0, bus.busy}, 32'd0);
        chk("to_error_held", {31'd0, bus.error}, 32'd1);

        // Next normal read clears error on accept.
        cfg_never = 0; cfg_lat = 0; cfg_word = 32'h0BADF00D;
        exp_q.push_back('{1'b0, 32'h0BADF00D});
        bus.start = 1'b1;
        tick();
        chk("rec_error_clr", {31'd0, bus.error}, 32'd0);
        tick();
        chk("rec_done", {31'd0, bus.done}, 32'd1);
        tick();
        bus.start = 1'b0;
        tick();

        // Stray readdatavalid while idle.
        stray_word = 32'h12345678;
        stray_req  = ~stray_req;
        repeat (3) tick();
        chk("stray_data", bus.data, 32'h0BADF00D);
        chk("stray_done", {31'd0, bus.done}, 32'd0);

        // Reset while waiting for data; the late word must be ignored.
        cfg_lat = 8; cfg_word = 32'hCAFEF00D;
        bus.start = 1'b1; bus.address = 23'h00042;
        tick();  // ISSUE
        tick();  // accepted, WAIT_DATA
        chk("mr_read_lo", {31'd0, bus.flash_mem_read}, 32'd0);
        chk("mr_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        reset_n = 1'b0;
        bus.start = 1'b0;
        #2;
        chk("mr_done", {31'd0, bus.done}, 32'd0);
        chk("mr_error", {31'd0, bus.error}, 32'd0);
        chk("mr_busy_lo", {31'd0, bus.busy}, 32'd0);
        chk("mr_data", bus.data, 32'd0);
        chk("mr_addr", {9'd0, bus.flash_mem_address}, 32'd0);
        chk("mr_be", {28'd0, bus.flash_mem_byteenable}, 32'd0);
        tick();
        reset_n = 1'b1;
        bad = 0;
        repeat (12) begin
            tick();
            if (bus.done !== 1'b0) bad++;
        end
        chk("mr_no_done", bad, 32'd0);
        chk("mr_data_kept", bus.data, 32'd0);

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
